// File: rtl/mem_access_unit.sv
// MEM-stage load/store sequencer: byte-lane alignment, sign/zero extension and one-cycle write-back.
// Optional feature: define MISALIGN_CHECK_EN to add a registered misalign flag that rejects unaligned accesses.
module mem_access_unit #(
  parameter int DATA_W = 64,
  parameter int RD_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              in_load,
  input  logic              in_store,
  input  logic [1:0]        in_size,
  input  logic              in_unsigned,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_wdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [DATA_W-1:0] mem_req_addr,
  output logic              mem_req_wen,
  output logic [DATA_W-1:0] mem_req_wdata,
  output logic [7:0]        mem_req_wmask,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_rdata,
  output logic              stall,
  output logic              wb_valid,
  output logic [RD_W-1:0]   wb_rd,
  output logic [DATA_W-1:0] wb_data
`ifdef MISALIGN_CHECK_EN
  ,
  output logic              misalign
`endif
);
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t            r_state, w_state_nxt;
  logic [DATA_W-1:0] r_addr, r_wdata;
  logic [RD_W-1:0]   r_rd;
  logic [1:0]        r_size;
  logic              r_unsigned, r_load;

  logic              w_mem_op, w_misal, w_accept, w_alu_wb, w_rsp_wb;
  logic [2:0]        w_off;
  logic [7:0]        w_size_mask;
  logic [DATA_W-1:0] w_rsp_shift, w_load_data, w_wdata_sz;

  // Address bits below the access size are dropped, so the lane is always size-aligned.
  function automatic logic [2:0] lane_off(input logic [2:0] a, input logic [1:0] sz);
    case (sz)
      2'd0:    lane_off = a;
      2'd1:    lane_off = {a[2:1], 1'b0};
      2'd2:    lane_off = {a[2], 2'b00};
      default: lane_off = 3'd0;
    endcase
  endfunction

  function automatic logic [7:0] byte_mask(input logic [1:0] sz);
    case (sz)
      2'd0:    byte_mask = 8'h01;
      2'd1:    byte_mask = 8'h03;
      2'd2:    byte_mask = 8'h0F;
      default: byte_mask = 8'hFF;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] bits_of(input logic [7:0] bm);
    bits_of = '0;
    for (int b = 0; b < 8; b++) bits_of[8*b +: 8] = {8{bm[b]}};
  endfunction

  function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] raw,
                                               input logic [1:0] sz, input logic uns);
    case (sz)
      2'd0:    extend = {{(DATA_W-8){~uns & raw[7]}}, raw[7:0]};
      2'd1:    extend = {{(DATA_W-16){~uns & raw[15]}}, raw[15:0]};
      2'd2:    extend = {{(DATA_W-32){~uns & raw[31]}}, raw[31:0]};
      default: extend = raw;
    endcase
  endfunction

`ifdef MISALIGN_CHECK_EN
  function automatic logic misaligned(input logic [2:0] a, input logic [1:0] sz);
    misaligned = (a & ~lane_off(3'b111, sz)) != 3'd0;
  endfunction
`endif

  always_comb begin
    w_mem_op = in_load | in_store;
`ifdef MISALIGN_CHECK_EN
    w_misal = misaligned(in_alu_result[2:0], in_size);
`else
    w_misal = 1'b0;
`endif
    w_state_nxt   = r_state;
    stall         = 1'b0;
    mem_req_valid = 1'b0;
    w_accept      = 1'b0;
    w_alu_wb      = 1'b0;
    w_rsp_wb      = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          if (!w_mem_op) begin
            w_alu_wb = 1'b1;
          end else if (!w_misal) begin
            w_accept    = 1'b1;
            stall       = 1'b1;
            w_state_nxt = REQ;
          end
        end
      end
      REQ: begin
        mem_req_valid = 1'b1;
        stall         = 1'b1;
        if (mem_req_ready) begin
          if (r_load) begin
            w_state_nxt = RESP;
          end else begin
            w_state_nxt = IDLE;
            stall       = 1'b0;
          end
        end
      end
      RESP: begin
        stall = 1'b1;
        if (mem_rsp_valid) begin
          w_rsp_wb    = 1'b1;
          stall       = 1'b0;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (rst) begin
      stall         = 1'b0;
      mem_req_valid = 1'b0;
    end
  end

  assign w_off         = lane_off(r_addr[2:0], r_size);
  assign w_size_mask   = byte_mask(r_size);
  assign w_wdata_sz    = r_wdata & bits_of(w_size_mask);
  assign w_rsp_shift   = mem_rsp_rdata >> {w_off, 3'b000};
  assign w_load_data   = extend(w_rsp_shift, r_size, r_unsigned);
  assign mem_req_addr  = mem_req_valid ? {r_addr[DATA_W-1:3], 3'b000} : '0;
  assign mem_req_wen   = mem_req_valid & ~r_load;
  assign mem_req_wdata = mem_req_wen ? (w_wdata_sz << {w_off, 3'b000}) : '0;
  assign mem_req_wmask = mem_req_wen ? (w_size_mask << w_off) : 8'h00;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      wb_valid <= 1'b0;
      if (w_alu_wb) begin
        wb_valid <= |in_rd;
        wb_rd    <= in_rd;
        wb_data  <= in_alu_result;
      end else if (w_rsp_wb) begin
        wb_valid <= |r_rd;
        wb_rd    <= r_rd;
        wb_data  <= w_load_data;
      end
    end
  end

  // Operation latch is data only; it is read solely while REQ/RESP are active.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_addr     <= in_alu_result;
      r_wdata    <= in_wdata;
      r_rd       <= in_rd;
      r_size     <= in_size;
      r_unsigned <= in_unsigned;
      r_load     <= in_load;
    end
  end

`ifdef MISALIGN_CHECK_EN
  logic r_misalign;
  always_ff @(posedge clk) begin
    if (rst) r_misalign <= 1'b0;
    else     r_misalign <= (r_state == IDLE) & in_valid & w_mem_op & w_misal;
  end
  assign misalign = r_misalign;
`endif
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed + randomized bench for mem_access_unit with a byte-arithmetic reference model.
module tb_mem_access_unit;
  localparam int DATA_W = 64;
  localparam int RD_W   = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid, in_load, in_store, in_unsigned;
  logic [RD_W-1:0]   in_rd;
  logic [1:0]        in_size;
  logic [DATA_W-1:0] in_alu_result, in_wdata;
  logic              mem_req_valid, mem_req_ready, mem_req_wen;
  logic [DATA_W-1:0] mem_req_addr, mem_req_wdata;
  logic [7:0]        mem_req_wmask;
  logic              mem_rsp_valid;
  logic [DATA_W-1:0] mem_rsp_rdata;
  logic              stall, wb_valid;
  logic [RD_W-1:0]   wb_rd;
  logic [DATA_W-1:0] wb_data;
`ifdef MISALIGN_CHECK_EN
  logic              misalign;
`endif

  int n_vec = 0;
  int n_err = 0;
  int last_stall_cnt;
  logic [63:0] last_ld;

  mem_access_unit #(.DATA_W(DATA_W), .RD_W(RD_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_rd(in_rd), .in_load(in_load), .in_store(in_store),
    .in_size(in_size), .in_unsigned(in_unsigned), .in_alu_result(in_alu_result),
    .in_wdata(in_wdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
    .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
    .stall(stall), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data)
`ifdef MISALIGN_CHECK_EN
    , .misalign(misalign)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_load = 0; in_store = 0; in_unsigned = 0; in_rd = '0; in_size = 2'd0;
    in_alu_result = '0; in_wdata = '0; mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_rdata = '0;
  endtask

  // Non-memory instruction: write-back one cycle later, no stall.
  task automatic alu_op(input logic [4:0] rd, input logic [63:0] val);
    in_valid = 1; in_load = 0; in_store = 0; in_rd = rd; in_alu_result = val;
    in_size = 2'($urandom); mem_rsp_valid = 1'($urandom);
    @(negedge clk);
    chk("alu_stall", stall, 0);
    chk("alu_reqv", mem_req_valid, 0);
    chk("alu_wb_quiet", wb_valid, 0);
    tick();
    idle_inputs();
    @(negedge clk);
    chk("alu_wbv", wb_valid, rd != 0);
    if (rd != 0) begin
      chk("alu_wbrd", wb_rd, rd);
      chk("alu_wbdata", wb_data, val);
    end
    tick();
  endtask

  // Memory op with ready after rdy_dly wait cycles and response after rsp_dly wait cycles.
  task automatic mem_op(input bit ld, input bit st, input logic [1:0] sz, input bit uns,
                        input logic [63:0] addr, input logic [63:0] wd, input logic [4:0] rd,
                        input logic [63:0] rdata, input int rdy_dly, input int rsp_dly);
    int nb, off, stall_cnt;
    bit is_ld;
    logic [63:0] dmask, exp_wd, bmask, exp_ld;
    logic [7:0] exp_wm;
    is_ld = ld;
    nb = 1 << sz;
    off = int'(addr[2:0]) & ~(nb - 1);
    dmask = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nb)) - 64'd1);
    exp_wm = 8'(((1 << nb) - 1) << off);
    exp_wd = (wd & dmask) << (8 * off);
    bmask = '0;
    for (int b = 0; b < 8; b++) if (exp_wm[b]) bmask[8*b +: 8] = 8'hFF;
    exp_ld = (rdata >> (8 * off)) & dmask;
    if (!uns && exp_ld[8*nb-1]) exp_ld = exp_ld | ~dmask;
    last_ld = exp_ld;
    stall_cnt = 0;

    in_valid = 1; in_load = ld; in_store = st; in_size = sz; in_unsigned = uns;
    in_alu_result = addr; in_wdata = wd; in_rd = rd; mem_req_ready = 0;
    mem_rsp_valid = 1'($urandom);
    @(negedge clk);
    chk("idle_stall", stall, 1);
    chk("idle_reqv", mem_req_valid, 0);
    if (stall) stall_cnt++;
    tick();
    for (int k = 0; k <= rdy_dly; k++) begin
      mem_req_ready = (k == rdy_dly);
      mem_rsp_valid = 1'($urandom);
      @(negedge clk);
      chk("req_valid", mem_req_valid, 1);
      chk("req_addr", mem_req_addr, {addr[63:3], 3'b000});
      chk("req_wen", mem_req_wen, !is_ld);
      if (!is_ld) begin
        chk("req_wmask", mem_req_wmask, exp_wm);
        chk("req_wdata", mem_req_wdata & bmask, exp_wd);
      end
      chk("req_stall", stall, !((k == rdy_dly) && !is_ld));
      chk("req_wb_quiet", wb_valid, 0);
      if (stall) stall_cnt++;
      tick();
    end
    if (is_ld) begin
      for (int k = 0; k <= rsp_dly; k++) begin
        mem_req_ready = 0;
        mem_rsp_valid = (k == rsp_dly);
        mem_rsp_rdata = (k == rsp_dly) ? rdata : {$urandom, $urandom};
        @(negedge clk);
        chk("resp_stall", stall, k != rsp_dly);
        chk("resp_reqv", mem_req_valid, 0);
        chk("resp_wb_quiet", wb_valid, 0);
        if (stall) stall_cnt++;
        tick();
      end
    end
    idle_inputs();
    @(negedge clk);
    chk("op_wbv", wb_valid, is_ld && (rd != 0));
    if (is_ld && rd != 0) begin
      chk("ld_wbrd", wb_rd, rd);
      chk("ld_wbdata", wb_data, exp_ld);
    end
    last_stall_cnt = stall_cnt;
    tick();
  endtask

  initial begin
    logic [63:0] ra, rdat, rwd;
    logic [1:0]  rsz;
    int          kind;

    idle_inputs();
    rst = 1;
    tick();
    tick();
    @(negedge clk);
    chk("rst_wbv", wb_valid, 0);
    chk("rst_wbrd", wb_rd, 0);
    chk("rst_wbdata", wb_data, 0);
    chk("rst_reqv", mem_req_valid, 0);
    chk("rst_addr", mem_req_addr, 0);
    chk("rst_wen", mem_req_wen, 0);
    chk("rst_wmask", mem_req_wmask, 0);
    chk("rst_wdata", mem_req_wdata, 0);
    chk("rst_stall", stall, 0);
`ifdef MISALIGN_CHECK_EN
    chk("rst_misalign", misalign, 0);
`endif
    // Instruction presented while reset is held must produce nothing.
    in_valid = 1; in_rd = 5'd9; in_alu_result = 64'h55;
    tick();
    @(negedge clk);
    chk("rst_hold_wbv", wb_valid, 0);
    tick();
    rst = 0;
    idle_inputs();
    tick();

    // Idle with memory flags but no valid: nothing starts.
    in_load = 1; in_store = 1; in_alu_result = 64'h100;
    @(negedge clk);
    chk("novalid_stall", stall, 0);
    tick();
    @(negedge clk);
    chk("novalid_reqv", mem_req_valid, 0);
    chk("novalid_wbv", wb_valid, 0);
    idle_inputs();
    tick();

    alu_op(5'd5, 64'h1234);
    alu_op(5'd0, 64'hDEAD);

    mem_op(1, 0, 2'd0, 0, 64'h8000_0003, 64'h0, 5'd1, 64'h0000_0000_8000_0000, 0, 0);
    chk("lb_const", last_ld, 64'hFFFF_FFFF_FFFF_FF80);
    chk("lb_stall_cycles", last_stall_cnt, 2);

    mem_op(0, 1, 2'd1, 0, 64'h8000_0006, 64'hBEEF, 5'd2, 64'h0, 3, 0);

    mem_op(1, 1, 2'd2, 1, 64'h40, 64'h0, 5'd3, 64'hFEDC_BA98_8765_4321, 1, 2);
    mem_op(1, 0, 2'd0, 0, 64'h41, 64'h0, 5'd0, 64'h0000_0000_0000_8000, 0, 0);

    // Reset during RESP abandons the load; the late response is ignored.
    in_valid = 1; in_load = 1; in_size = 2'd3; in_alu_result = 64'h1000; in_rd = 5'd7;
    tick();
    mem_req_ready = 1;
    tick();
    in_valid = 0; in_load = 0; mem_req_ready = 0;
    @(negedge clk);
    chk("resp_pre_rst_stall", stall, 1);
    rst = 1;
    tick();
    rst = 0;
    mem_rsp_valid = 1; mem_rsp_rdata = 64'h1111_2222_3333_4444;
    @(negedge clk);
    chk("abandon_stall", stall, 0);
    chk("abandon_reqv", mem_req_valid, 0);
    tick();
    mem_rsp_valid = 0;
    @(negedge clk);
    chk("abandon_wbv", wb_valid, 0);
    chk("abandon_reqv2", mem_req_valid, 0);
    tick();
    alu_op(5'd12, 64'hABCD);

`ifdef MISALIGN_CHECK_EN
    in_valid = 1; in_load = 1; in_size = 2'd2; in_alu_result = 64'h2; in_rd = 5'd3;
    @(negedge clk);
    chk("mis_stall", stall, 0);
    chk("mis_reqv", mem_req_valid, 0);
    tick();
    idle_inputs();
    @(negedge clk);
    chk("mis_flag", misalign, 1);
    chk("mis_wbv", wb_valid, 0);
    chk("mis_reqv2", mem_req_valid, 0);
    tick();
    @(negedge clk);
    chk("mis_flag_pulse", misalign, 0);
    tick();
`endif

    for (int i = 0; i < 60; i++) begin
      kind = int'($urandom_range(0, 3));
      rsz  = 2'($urandom);
      ra   = {$urandom, $urandom};
      rdat = {$urandom, $urandom};
      rwd  = {$urandom, $urandom};
`ifdef MISALIGN_CHECK_EN
      ra[2:0] = ra[2:0] & 3'(~((1 << rsz) - 1));
`endif
      if (kind == 0)
        alu_op(5'($urandom), ra);
      else
        mem_op(kind != 2, kind != 1, rsz, 1'($urandom), ra, rwd, 5'($urandom), rdat,
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
